// File: rtl/pio_pkg.sv
// Shared PIO package: data width, default FIFO depth and FIFO status
// encodings used by the PIO FIFOs and the logic that reads their status.
package pio_pkg;

  localparam int unsigned PIO_DATA_WIDTH = 32;
  localparam int unsigned PIO_FIFO_DEPTH = 4;

  localparam logic [1:0] FIFO_STATUS_PARTIAL = 2'b00;
  localparam logic [1:0] FIFO_STATUS_EMPTY   = 2'b01;
  localparam logic [1:0] FIFO_STATUS_FULL    = 2'b10;

endpackage : pio_pkg

// File: rtl/pio_fifo_ptr.sv
// Wrapping FIFO pointer. Counts modulo DEPTH, so DEPTH must be a power
// of two; the wrap is the natural rollover of the register.
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-high reset, clears the pointer
//   inc_en_i - advance the pointer by one on the next edge
//   ptr_o    - current pointer value
module pio_fifo_ptr #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inc_en_i,
  output logic [$clog2(DEPTH)-1:0] ptr_o
);

  localparam int unsigned PTR_WIDTH = $clog2(DEPTH);

  logic [PTR_WIDTH-1:0] ptr_q;
  logic [PTR_WIDTH-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_en_i) begin
      ptr_d = ptr_q + PTR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule : pio_fifo_ptr

// File: rtl/pio_fifo.sv
// PIO first-word-fall-through FIFO, one instance per direction (TX/RX).
// The head entry is presented combinationally from storage; status and
// count are decoded from the registered occupancy counter only, so no
// input reaches any output without passing through a register.
// Ports:
//   clk        - rising-edge clock
//   rst        - asynchronous active-high reset (pointers/count/flags)
//   data_in    - write data, captured on an accepted push
//   push_en    - push request
//   pop_en     - pop request
//   data_out   - head entry, 0 while empty
//   status     - {full, empty}
//   fifo_count - occupancy, 0..DEPTH
// Optional feature macro PIO_FIFO_ERR_EN adds sticky error outputs:
//   overflow   - set by a push rejected because the FIFO was full
//   underflow  - set by a pop request while empty
module pio_fifo
  import pio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PIO_DATA_WIDTH,
  parameter int unsigned DEPTH      = PIO_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   push_en,
  input  logic                   pop_en,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic [1:0]             status,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef PIO_FIFO_ERR_EN
  ,
  output logic                   overflow,
  output logic                   underflow
`endif
);

  localparam int unsigned PTR_WIDTH   = $clog2(DEPTH);
  localparam int unsigned COUNT_WIDTH = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr;
  logic [PTR_WIDTH-1:0]   rd_ptr;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;
  logic                   empty;
  logic                   full;
  logic                   push_acc;
  logic                   pop_acc;

  assign empty = (count_q == '0);
  assign full  = (count_q == COUNT_WIDTH'(DEPTH));

  // A pop frees the slot in the same edge, so a push into a full FIFO
  // is still accepted when it is paired with an accepted pop.
  assign pop_acc  = pop_en && !empty;
  assign push_acc = push_en && (!full || pop_acc);

  pio_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk      (clk),
    .rst      (rst),
    .inc_en_i (push_acc),
    .ptr_o    (wr_ptr)
  );

  pio_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk      (clk),
    .rst      (rst),
    .inc_en_i (pop_acc),
    .ptr_o    (rd_ptr)
  );

  // Storage is deliberately not reset; the count gates what is visible.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem_q[wr_ptr] <= data_in;
    end
  end

  always_comb begin
    count_d = count_q;
    if (push_acc && !pop_acc) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end else if (pop_acc && !push_acc) begin
      count_d = count_q - COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign data_out   = empty ? '0 : mem_q[rd_ptr];
  assign fifo_count = count_q;

  always_comb begin
    status = FIFO_STATUS_PARTIAL;
    if (empty) begin
      status = FIFO_STATUS_EMPTY;
    end else if (full) begin
      status = FIFO_STATUS_FULL;
    end
  end

`ifdef PIO_FIFO_ERR_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_en && !push_acc) begin
        overflow_q <= 1'b1;
      end
      if (pop_en && empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule : pio_fifo

// File: tb/tb_pio_fifo.sv
// Bench for pio_fifo: directed steps push their hand-computed post-edge
// expectations into a queue; a monitor pops and compares after each edge.
module tb_pio_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in = '0;
  logic        push_en = 1'b0;
  logic        pop_en = 1'b0;
  logic [31:0] data_out;
  logic [1:0]  status;
  logic [2:0]  fifo_count;
`ifdef PIO_FIFO_ERR_EN
  logic        overflow;
  logic        underflow;
`endif

  pio_fifo dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .push_en    (push_en),
    .pop_en     (pop_en),
    .data_out   (data_out),
    .status     (status),
    .fifo_count (fifo_count)
`ifdef PIO_FIFO_ERR_EN
    ,
    .overflow   (overflow),
    .underflow  (underflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int unsigned cnt;
    int unsigned stat;
    logic [31:0] dout;
    bit          ovf;
    bit          unf;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   exp_ovf = 1'b0;
  bit   exp_unf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus; expectations describe the state after the edge.
  task automatic step(input string name, input bit psh, input bit pp, input logic [31:0] din,
                      input int unsigned cnt, input int unsigned stat, input logic [31:0] dout);
    exp_t e;
    @(negedge clk);
    push_en = psh;
    pop_en  = pp;
    data_in = din;
    e.name = name;
    e.cnt  = cnt;
    e.stat = stat;
    e.dout = dout;
    e.ovf  = exp_ovf;
    e.unf  = exp_unf;
    sb_q.push_back(e);
  endtask

  // Monitor: compares once per edge whenever an expectation is pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk({e.name, ".count"}, 32'(fifo_count), 32'(e.cnt));
        chk({e.name, ".status"}, 32'(status), 32'(e.stat));
        chk({e.name, ".data_out"}, data_out, e.dout);
`ifdef PIO_FIFO_ERR_EN
        chk({e.name, ".overflow"}, 32'(overflow), 32'(e.ovf));
        chk({e.name, ".underflow"}, 32'(underflow), 32'(e.unf));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset.count", 32'(fifo_count), 32'd0);
    chk("reset.status", 32'(status), 32'd1);
    chk("reset.data_out", data_out, 32'd0);

    // Fill from empty
    step("fill_a", 1, 0, 32'hA, 1, 0, 32'hA);
    step("fill_b", 1, 0, 32'hB, 2, 0, 32'hA);
    step("fill_c", 1, 0, 32'hC, 3, 0, 32'hA);
    step("fill_d", 1, 0, 32'hD, 4, 2, 32'hA);

    // Rejected push while full
    exp_ovf = 1'b1;
    step("push_full", 1, 0, 32'hE, 4, 2, 32'hA);

    // Drain, then pop while empty
    step("drain1", 0, 1, 32'h0, 3, 0, 32'hB);
    step("drain2", 0, 1, 32'h0, 2, 0, 32'hC);
    step("drain3", 0, 1, 32'h0, 1, 0, 32'hD);
    step("drain4", 0, 1, 32'h0, 0, 1, 32'h0);
    exp_unf = 1'b1;
    step("pop_empty", 0, 1, 32'h0, 0, 1, 32'h0);

    // Simultaneous push/pop while full
    step("refill_a", 1, 0, 32'hA, 1, 0, 32'hA);
    step("refill_b", 1, 0, 32'hB, 2, 0, 32'hA);
    step("refill_c", 1, 0, 32'hC, 3, 0, 32'hA);
    step("refill_d", 1, 0, 32'hD, 4, 2, 32'hA);
    step("pushpop_full", 1, 1, 32'h5, 4, 2, 32'hB);
    step("pp_drain1", 0, 1, 32'h0, 3, 0, 32'hC);
    step("pp_drain2", 0, 1, 32'h0, 2, 0, 32'hD);
    step("pp_drain3", 0, 1, 32'h0, 1, 0, 32'h5);
    step("pp_drain4", 0, 1, 32'h0, 0, 1, 32'h0);

    // Pop while empty is ignored even with a concurrent push
    step("pop_empty_push", 1, 1, 32'h77, 1, 0, 32'h77);
    step("pop_77", 0, 1, 32'h0, 0, 1, 32'h0);

    // Delay line: push and pop held from empty
    for (int i = 1; i <= 6; i++) begin
      step($sformatf("delay%0d", i), 1, 1, 32'(i), 1, 0, 32'(i));
    end
    step("delay_end", 0, 1, 32'h0, 0, 1, 32'h0);

    // Mixed traffic crossing the pointer wrap
    step("wrap1", 1, 0, 32'h10, 1, 0, 32'h10);
    step("wrap2", 1, 0, 32'h11, 2, 0, 32'h10);
    step("wrap3", 1, 0, 32'h12, 3, 0, 32'h10);
    step("wrap4", 1, 1, 32'h13, 3, 0, 32'h11);
    step("wrap5", 0, 1, 32'h0, 2, 0, 32'h12);
    step("wrap6", 1, 0, 32'h14, 3, 0, 32'h12);
    step("wrap7", 1, 1, 32'h15, 3, 0, 32'h13);
    step("wrap8", 0, 1, 32'h0, 2, 0, 32'h14);
    step("wrap9", 0, 1, 32'h0, 1, 0, 32'h15);
    step("wrap10", 0, 1, 32'h0, 0, 1, 32'h0);

    // Asynchronous reset in the middle of traffic
    step("pre_rst1", 1, 0, 32'h21, 1, 0, 32'h21);
    step("pre_rst2", 1, 0, 32'h22, 2, 0, 32'h21);
    @(negedge clk);
    push_en = 1'b1;
    data_in = 32'h23;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst.count", 32'(fifo_count), 32'd0);
    chk("midrst.status", 32'(status), 32'd1);
    chk("midrst.data_out", data_out, 32'd0);
`ifdef PIO_FIFO_ERR_EN
    chk("midrst.overflow", 32'(overflow), 32'd0);
    chk("midrst.underflow", 32'(underflow), 32'd0);
`endif
    @(negedge clk);
    push_en = 1'b0;
    rst = 1'b0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    step("post_rst_push", 1, 0, 32'h31, 1, 0, 32'h31);
    step("post_rst_pop", 0, 1, 32'h0, 0, 1, 32'h0);
    step("idle", 0, 0, 32'h0, 0, 1, 32'h0);

    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_pio_fifo

// File: doc/pio_fifo.md
# pio_fifo

Synchronous first-word-fall-through FIFO for the PIO core, one instance per direction: TX (host → state machine) and RX (GPIO sample → host). Each entry is 32 bits, the default depth is 4, and full/empty status plus an occupancy count are exported for the state machine and host logic. The core stalls on the `status`/`fifo_count` outputs, so these must be exact every cycle.

## Interface
Parameters:
- `DATA_WIDTH`, 32: entry width in bits.
- `DEPTH`, 4: number of entries; must be a power of two and ≥ 2.
- `COUNT_WIDTH`, $clog2(DEPTH)+1: local parameter, not overridable; width of the occupancy count.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-high reset.
- `data_in`  in  DATA_WIDTH: write data, sampled on a push.
- `push_en`  in  1: push request.
- `pop_en`  in  1: pop request.
- `data_out`  out  DATA_WIDTH: head entry, first-word-fall-through.
- `status`  out  2: bit 0 = empty, bit 1 = full.
- `fifo_count`  out  COUNT_WIDTH: occupancy, 0..DEPTH.

## Operation
- Storage: circular buffer of DEPTH entries. `wr_ptr` and `rd_ptr` are each $clog2(DEPTH) bits and wrap modulo DEPTH. `fifo_count` is a separate registered counter.
- Push accepted = `push_en` && (not full || pop accepted). An accepted push writes `data_in` at `wr_ptr` and increments `wr_ptr`.
- Pop accepted = `pop_en` && not empty. An accepted pop increments `rd_ptr`.
- Count update: push only → +1; pop only → −1; both accepted or neither → unchanged.
- Push when full without a pop: data is dropped, no state changes.
- Pop when empty: ignored, even if a push occurs in the same cycle. The pushed word appears on `data_out` the next cycle.
- Push and pop together when full: both are accepted and the count stays at DEPTH.
- Constant push_en = pop_en = 1 from empty: the first cycle fills one entry. After that the FIFO acts as a 1-cycle delay line with count = 1.
- `data_out` = storage[`rd_ptr`] when not empty, and 0 when empty.
- `status` encodings:
  - 2'b01 when count = 0.
  - 2'b10 when count = DEPTH.
  - 2'b00 otherwise.
  - 2'b11 must never occur.
- Reset: ptrs = 0, count = 0, `status` = 01, `data_out` = 0. Storage contents are not reset. Reset asserted mid-operation discards all entries immediately.

## Timing
- Push, pop, and count all update on the rising edge of `clk`. `status` and `fifo_count` reflect the new state in the same cycle the registers change.
- Write-to-read latency: 1 cycle. A word pushed at edge N is visible on `data_out` after edge N.
- `data_out` is combinational from `rd_ptr`/storage; no extra pipeline register.
- Pop-to-next-head: the new head is visible immediately after the popping edge.
- There are no combinational paths from `push_en`/`pop_en`/`data_in` to any output.

## Configuration
Macro `PIO_FIFO_ERR_EN`:
- Defined: adds outputs `overflow` (1 bit) and `underflow` (1 bit).
  - `overflow` is a sticky flag, set by a rejected push (push_en while full, no pop).
  - `underflow` is a sticky flag, set by pop_en while empty.
  - Both reset to 0 and clear only on `rst`.
- Undefined: these ports and registers are absent, and rejected operations are silently ignored.

## Structure
- Shared package `pio_pkg` holds:
  - `PIO_DATA_WIDTH` = 32.
  - `PIO_FIFO_DEPTH` = 4.
  - Status constants `FIFO_STATUS_PARTIAL` = 2'b00, `FIFO_STATUS_EMPTY` = 2'b01, `FIFO_STATUS_FULL` = 2'b10.
- A single sub-module is natural: `pio_fifo_ptr`, a wrapping pointer register with increment enable, instantiated for the read and write pointers.
- Storage is inferred inside `pio_fifo`.

## Test plan
- Reset with `rst` asserted mid-traffic → count 0, `status` 01, `data_out` 0, immediately without waiting for a clock edge.
- Push 0xA, 0xB, 0xC, 0xD into an empty FIFO → counts 1, 2, 3, 4; `status` goes 00, then 10 at 4; `data_out` shows 0xA from the first edge on.
- Full FIFO, push 0xE alone → count stays 4 and 0xE is lost. Then pop 4 times → `data_out` sequence 0xA, 0xB, 0xC, 0xD, then 0 with `status` 01.
- Full FIFO, push 0x5 with a simultaneous pop → count stays 4, head advances from 0xA to 0xB, and 0x5 is returned after 0xB, 0xC, 0xD.
- Empty FIFO, push_en = pop_en = 1 held with `data_in` = 1, 2, 3… → count 1 after the first edge and then constant; `data_out` lags `data_in` by one cycle.
- 10 push/pop cycles crossing the pointer wrap → FIFO order preserved. With `PIO_FIFO_ERR_EN` defined, overflow/underflow attempts set the sticky flags and they stay set until `rst`.
